lcd_ctrl_param: RTL and testbench
=================================

// Module: lcd_ctrl_param
// PURPOSE
//  Parametrised image-display controller. Loads an IMG_W x IMG_H frame into an internal pixel buffer.
//  Streams a WIN x WIN view, one pixel per cycle, in one of two modes: fit (subsampled full frame)
//  or zoom (1:1 window). Supports rotation in both modes, a true 180-degree turn and clamped panning.
//  Sits between the frame source (cmd/datain) and the panel driver (dataout/output_valid).
// PARAMETERS
//  DW     8  pixel width in bits
//  IMG_W 12  frame width in pixels
//  IMG_H  9  frame height in pixels
//  WIN    4  view edge in pixels; WIN<=IMG_W, WIN<=IMG_H
//  ORG_X0 4  zoom origin column after reset and after zoom-in
//  ORG_Y0 3  zoom origin row after reset and after zoom-in
// PORTS
//  clk           in   1   clock, rising edge
//  reset_n       in   1   asynchronous reset, active-low
//  datain        in   DW  frame pixel, raster order, during LOAD
//  cmd           in   4   command code, sampled when cmd_valid=1 and busy=0
//  cmd_valid     in   1   command strobe
//  dataout       out  DW  view pixel
//  output_valid  out  1   dataout is valid this cycle
//  busy          out  1   command in progress; cmd_valid is ignored while high
// BEHAVIOUR
//  Reset values: busy=0, output_valid=0, dataout=0, rot=0, zoom=0 (fit), origin=(ORG_X0,ORG_Y0), mirror=0.
//  Buffer contents are not reset. Asserting reset_n low mid-command aborts it at once.
//  Commands: 0 LOAD, 1 ROT_L (rot-1 mod 4), 2 ROT_R (rot+1 mod 4), 3 ZOOM_IN, 4 ZOOM_FIT,
//  5 SHIFT_R, 6 SHIFT_L, 7 SHIFT_U, 8 SHIFT_D.
//  A command is accepted on an edge where cmd_valid=1 and busy=0. Any other code is ignored and busy stays 0.
//  FSM: IDLE -> (LOAD) LOADING -> SHOW -> DONE -> IDLE; any other accepted command goes IDLE -> SHOW.
//  Timing, command accepted at edge k:
//   - busy=1 from edge k.
//   - LOAD only: datain is sampled at edges k+1..k+N, N=IMG_W*IMG_H, into buf[row*IMG_W+col]; set L=N, else L=0.
//   - View pixels p=0..WIN*WIN-1 are driven with output_valid=1 after edge k+L+1+p.
//   - After edge k+L+1+WIN*WIN: output_valid=0 and busy=0. dataout holds its last value.
//  LOAD clears rot and mirror; zoom mode and origin are unchanged.
//  ROT_L/ROT_R apply in both modes.
//  ZOOM_IN: zoom=1, origin reset to (ORG_X0,ORG_Y0). ZOOM_FIT: zoom=0.
//  Every accepted command ends with a full view redisplay.
//  View mapping: display (r,c), p=r*WIN+c, maps to window coordinates (wr,wc):
//   - rot0 (r,c); rot1 (WIN-1-c, r); rot2 (WIN-1-r, WIN-1-c); rot3 (c, WIN-1-r).
//   - Fit source pixel: (FOY+wr*FSY, FOX+wc*FSX), with FSX=IMG_W/WIN, FSY=IMG_H/WIN, FOX=FSX/2, FOY=FSY/2.
//   - Zoom source pixel: (oy+wr, ox+wc).
//  Shifts act in display direction; in fit mode they are no-ops but still redisplay.
//   - Source displacement of display-Right / display-Down: rot0 +x/+y, rot1 -y/+x, rot2 -x/-y, rot3 +y/-x.
//   - Left = -Right; Up = -Down.
//   - ox clamps to [0, IMG_W-WIN]; oy clamps to [0, IMG_H-WIN]. A shift at a limit leaves the origin unchanged.
//  Address arithmetic: unsigned, $clog2(IMG_W*IMG_H) bits. Origin widths are $clog2(IMG_W) and $clog2(IMG_H).
// CONFIGURATION
//  LCD_MIRROR_EN defined:
//   - cmd 9 MIRROR toggles mirror; it is cleared by LOAD and reset.
//   - When mirror=1: c is replaced by WIN-1-c before rotation mapping, and Right/Left displacements are negated.
//  LCD_MIRROR_EN undefined: cmd 9 is ignored like any unknown code; no mirror register exists.
// STRUCTURE
//  Package lcd_ctrl_pkg holds:
//   - cmd_e, the command enum 0..9;
//   - rot_t, 2 bits;
//   - state_e: IDLE, LOADING, SHOW, DONE;
//   - localparam helpers for FSX/FSY/FOX/FOY.
//  Sub-module lcd_view_addr: combinational (p, rot, mirror, zoom, ox, oy) -> buffer address.
//  The top level holds the FSM, counters, origin/rot registers and the buffer array.
// TESTING
//  - Reset; LOAD with buf[i]=i. Outputs at offsets +1..+16 after load end: 13,16,19,22,37,40,43,46,61,64,67,70,85,88,91,94.
//    Then busy=0.
//  - After load: ROT_R, ROT_R (rot2, fit) -> 94,91,88,85,...,22,19,16,13. ROT_R again (rot3) -> first pixel 22.
//  - ZOOM_IN -> 40,41,42,43,52,...,79. SHIFT_R x10 -> ox clamps at 8, last view starts 44.
//    SHIFT_D x10 -> oy=5, first pixel 68.
//  - rot1 zoom at origin (0,0): SHIFT_R -> oy stays 0. SHIFT_D -> ox=1, first pixel (row3,col1)=37.
//  - cmd_valid held high while busy with cmd=3 -> ignored; cmd=12 while idle -> busy stays 0.
//    reset_n low mid-SHOW -> busy=0, output_valid=0 in the same cycle.
//  - LCD_MIRROR_EN: fit rot0, MIRROR -> 22,19,16,13,46,... Without the macro, cmd 9 -> no busy.

Source files
------------

// File: rtl/lcd_ctrl_pkg.sv
// Shared command/state types and fit-geometry helpers for the lcd_ctrl_param display controller.
package lcd_ctrl_pkg;

  typedef enum logic [3:0] {
    CMD_LOAD     = 4'd0,
    CMD_ROT_L    = 4'd1,
    CMD_ROT_R    = 4'd2,
    CMD_ZOOM_IN  = 4'd3,
    CMD_ZOOM_FIT = 4'd4,
    CMD_SHIFT_R  = 4'd5,
    CMD_SHIFT_L  = 4'd6,
    CMD_SHIFT_U  = 4'd7,
    CMD_SHIFT_D  = 4'd8,
    CMD_MIRROR   = 4'd9
  } cmd_e;

  typedef logic [1:0] rot_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    SHOW    = 2'd2,
    DONE    = 2'd3
  } state_e;

  // Fit mode samples every (extent/win)-th pixel, starting half a step in.
  function automatic int fit_step(input int extent, input int win);
    return extent / win;
  endfunction

  function automatic int fit_off(input int extent, input int win);
    return (extent / win) / 2;
  endfunction

  function automatic int min_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lcd_view_addr.sv
// Combinational view-pixel to buffer-address mapper: mirror, rotation, then fit subsampling or zoom window.
module lcd_view_addr import lcd_ctrl_pkg::*; #(
  parameter  int IMG_W = 12,
  parameter  int IMG_H = 9,
  parameter  int WIN   = 4,
  localparam int AW    = min_width(IMG_W * IMG_H),
  localparam int PW    = min_width(WIN * WIN),
  localparam int OXW   = min_width(IMG_W),
  localparam int OYW   = min_width(IMG_H)
) (
  input  logic [PW-1:0]  i_p,
  input  rot_t           i_rot,
  input  logic           i_mirror,
  input  logic           i_zoom,
  input  logic [OXW-1:0] i_ox,
  input  logic [OYW-1:0] i_oy,
  output logic [AW-1:0]  o_addr
);

  localparam int CW  = min_width(WIN);
  localparam int FSX = fit_step(IMG_W, WIN);
  localparam int FSY = fit_step(IMG_H, WIN);
  localparam int FOX = fit_off(IMG_W, WIN);
  localparam int FOY = fit_off(IMG_H, WIN);
  localparam logic [CW-1:0] EDGE = CW'(WIN - 1);

  logic [CW-1:0] w_r;
  logic [CW-1:0] w_c;
  logic [CW-1:0] w_cm;
  logic [CW-1:0] w_wr;
  logic [CW-1:0] w_wc;
  logic [AW-1:0] w_row;
  logic [AW-1:0] w_col;

  assign w_r  = CW'(i_p / PW'(WIN));
  assign w_c  = CW'(i_p % PW'(WIN));
  assign w_cm = i_mirror ? (EDGE - w_c) : w_c;

  // Display (r,c) to window (wr,wc); mirroring is applied before the turn.
  always_comb begin
    w_wr = w_r;
    w_wc = w_cm;
    case (i_rot)
      2'd0: begin
        w_wr = w_r;
        w_wc = w_cm;
      end
      2'd1: begin
        w_wr = EDGE - w_cm;
        w_wc = w_r;
      end
      2'd2: begin
        w_wr = EDGE - w_r;
        w_wc = EDGE - w_cm;
      end
      default: begin
        w_wr = w_cm;
        w_wc = EDGE - w_r;
      end
    endcase
  end

  assign w_row = i_zoom ? (AW'(i_oy) + AW'(w_wr))
                        : (AW'(FOY) + AW'(w_wr) * AW'(FSY));
  assign w_col = i_zoom ? (AW'(i_ox) + AW'(w_wc))
                        : (AW'(FOX) + AW'(w_wc) * AW'(FSX));

  assign o_addr = w_row * AW'(IMG_W) + w_col;

endmodule

// File: rtl/lcd_ctrl_param.sv
// Image-display controller top: command FSM, pixel buffer, rotation/zoom/pan state and view streaming.
// Optional feature: define LCD_MIRROR_EN to enable the MIRROR command (cmd 9) and the mirror register.
module lcd_ctrl_param import lcd_ctrl_pkg::*; #(
  parameter int DW     = 8,
  parameter int IMG_W  = 12,
  parameter int IMG_H  = 9,
  parameter int WIN    = 4,
  parameter int ORG_X0 = 4,
  parameter int ORG_Y0 = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [DW-1:0] datain,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  output logic [DW-1:0] dataout,
  output logic          output_valid,
  output logic          busy
);

  localparam int N    = IMG_W * IMG_H;
  localparam int NPIX = WIN * WIN;
  localparam int AW   = min_width(N);
  localparam int PW   = min_width(NPIX);
  localparam int OXW  = min_width(IMG_W);
  localparam int OYW  = min_width(IMG_H);

  localparam logic [OXW-1:0] OX_MAX    = OXW'(IMG_W - WIN);
  localparam logic [OYW-1:0] OY_MAX    = OYW'(IMG_H - WIN);
  localparam logic [OXW-1:0] OX_RST    = OXW'(ORG_X0);
  localparam logic [OYW-1:0] OY_RST    = OYW'(ORG_Y0);
  localparam logic [AW-1:0]  LOAD_LAST = AW'(N - 1);
  localparam logic [PW-1:0]  PIX_LAST  = PW'(NPIX - 1);

  logic [DW-1:0]  r_buf [0:N-1];
  state_e         r_state;
  logic           r_busy;
  logic           r_valid;
  logic [DW-1:0]  r_dataout;
  rot_t           r_rot;
  logic           r_zoom;
  logic [OXW-1:0] r_ox;
  logic [OYW-1:0] r_oy;
  logic [AW-1:0]  r_cnt;
  logic [PW-1:0]  r_p;

  cmd_e             w_cmd;
  logic             w_known;
  logic             w_accept;
  logic             w_mirror;
  logic [AW-1:0]    w_addr;
  logic signed [1:0] w_right;
  logic signed [1:0] w_down;
  logic signed [1:0] w_dx;
  logic signed [1:0] w_dy;
  logic [OXW-1:0]   w_oxNext;
  logic [OYW-1:0]   w_oyNext;

`ifdef LCD_MIRROR_EN
  logic r_mirror;
  assign w_mirror = r_mirror;
  assign w_known  = (cmd <= 4'd9);
`else
  assign w_mirror = 1'b0;
  assign w_known  = (cmd <= 4'd8);
`endif

  assign w_cmd    = cmd_e'(cmd);
  assign w_accept = cmd_valid && (r_state == IDLE) && w_known;

  // Turn a display-direction shift into a source-origin step under the current rotation.
  always_comb begin
    w_right = 2'sd0;
    w_down  = 2'sd0;
    w_dx    = 2'sd0;
    w_dy    = 2'sd0;
    case (w_cmd)
      CMD_SHIFT_R: w_right = 2'sd1;
      CMD_SHIFT_L: w_right = -2'sd1;
      CMD_SHIFT_D: w_down  = 2'sd1;
      CMD_SHIFT_U: w_down  = -2'sd1;
      default: ;
    endcase
    if (w_mirror) w_right = -w_right;
    case (r_rot)
      2'd0: begin
        w_dx = w_right;
        w_dy = w_down;
      end
      2'd1: begin
        w_dx = w_down;
        w_dy = -w_right;
      end
      2'd2: begin
        w_dx = -w_right;
        w_dy = -w_down;
      end
      default: begin
        w_dx = -w_down;
        w_dy = w_right;
      end
    endcase
  end

  always_comb begin
    w_oxNext = r_ox;
    w_oyNext = r_oy;
    if (w_dx == 2'sd1 && r_ox != OX_MAX)       w_oxNext = r_ox + OXW'(1);
    else if (w_dx == -2'sd1 && r_ox != '0)     w_oxNext = r_ox - OXW'(1);
    if (w_dy == 2'sd1 && r_oy != OY_MAX)       w_oyNext = r_oy + OYW'(1);
    else if (w_dy == -2'sd1 && r_oy != '0)     w_oyNext = r_oy - OYW'(1);
  end

  lcd_view_addr #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .WIN   (WIN)
  ) u_view_addr (
    .i_p      (r_p),
    .i_rot    (r_rot),
    .i_mirror (w_mirror),
    .i_zoom   (r_zoom),
    .i_ox     (r_ox),
    .i_oy     (r_oy),
    .o_addr   (w_addr)
  );

  // Frame contents survive reset, so the buffer lives in its own unreset block.
  always_ff @(posedge clk) begin
    if (r_state == LOADING) r_buf[r_cnt] <= datain;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_dataout <= '0;
      r_rot     <= '0;
      r_zoom    <= 1'b0;
      r_ox      <= OX_RST;
      r_oy      <= OY_RST;
      r_cnt     <= '0;
      r_p       <= '0;
`ifdef LCD_MIRROR_EN
      r_mirror  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_p     <= '0;
            r_state <= (w_cmd == CMD_LOAD) ? LOADING : SHOW;
            case (w_cmd)
              CMD_LOAD: begin
                r_rot    <= '0;
`ifdef LCD_MIRROR_EN
                r_mirror <= 1'b0;
`endif
              end
              CMD_ROT_L:    r_rot <= r_rot - 2'd1;
              CMD_ROT_R:    r_rot <= r_rot + 2'd1;
              CMD_ZOOM_IN: begin
                r_zoom <= 1'b1;
                r_ox   <= OX_RST;
                r_oy   <= OY_RST;
              end
              CMD_ZOOM_FIT: r_zoom <= 1'b0;
`ifdef LCD_MIRROR_EN
              CMD_MIRROR:   r_mirror <= !r_mirror;
`endif
              default: begin
                if (r_zoom) begin
                  r_ox <= w_oxNext;
                  r_oy <= w_oyNext;
                end
              end
            endcase
          end
        end
        LOADING: begin
          r_cnt <= r_cnt + AW'(1);
          if (r_cnt == LOAD_LAST) r_state <= SHOW;
        end
        SHOW: begin
          r_dataout <= r_buf[w_addr];
          r_valid   <= 1'b1;
          r_p       <= r_p + PW'(1);
          if (r_p == PIX_LAST) r_state <= DONE;
        end
        DONE: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dataout      = r_dataout;
  assign output_valid = r_valid;
  assign busy         = r_busy;

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Self-checking bench for lcd_ctrl_param: directed scenarios plus randomized command streams against a behavioural model.
module tb_lcd_ctrl_param;

  localparam int DW     = 8;
  localparam int IMG_W  = 12;
  localparam int IMG_H  = 9;
  localparam int WIN    = 4;
  localparam int ORG_X0 = 4;
  localparam int ORG_Y0 = 3;
  localparam int N      = IMG_W * IMG_H;
  localparam int NPIX   = WIN * WIN;
  localparam int FSX    = IMG_W / WIN;
  localparam int FSY    = IMG_H / WIN;
  localparam int FOX    = FSX / 2;
  localparam int FOY    = FSY / 2;

`ifdef LCD_MIRROR_EN
  localparam bit MIRROR_ON = 1'b1;
`else
  localparam bit MIRROR_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] datain;
  logic [3:0]    cmd;
  logic          cmd_valid;
  logic [DW-1:0] dataout;
  logic          output_valid;
  logic          busy;

  int checkCount = 0;
  int errorCount = 0;

  int frame [N];
  int nextFrame [N];
  int mRot, mZoom, mOx, mOy, mMirror;
  int firstPix, lastPix;

  // Source displacement of display-Right and display-Down, indexed by rotation.
  int rightX [4] = '{1, 0, -1, 0};
  int rightY [4] = '{0, -1, 0, 1};
  int downX  [4] = '{0, 1, 0, -1};
  int downY  [4] = '{1, 0, -1, 0};

  always #5 clk = ~clk;

  lcd_ctrl_param #(
    .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN), .ORG_X0(ORG_X0), .ORG_Y0(ORG_Y0)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .datain       (datain),
    .cmd          (cmd),
    .cmd_valid    (cmd_valid),
    .dataout      (dataout),
    .output_valid (output_valid),
    .busy         (busy)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed != expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic void modelReset();
    mRot = 0; mZoom = 0; mOx = ORG_X0; mOy = ORG_Y0; mMirror = 0;
  endfunction

  function automatic bit isKnown(input int code);
    return (code <= 8) || (MIRROR_ON && code == 9);
  endfunction

  function automatic int clampInt(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic void modelAccept(input int code);
    int sR, sD;
    case (code)
      0: begin frame = nextFrame; mRot = 0; mMirror = 0; end
      1: mRot = (mRot + 3) % 4;
      2: mRot = (mRot + 1) % 4;
      3: begin mZoom = 1; mOx = ORG_X0; mOy = ORG_Y0; end
      4: mZoom = 0;
      9: mMirror = 1 - mMirror;
      default: begin
        sR = (code == 5) ? 1 : ((code == 6) ? -1 : 0);
        sD = (code == 8) ? 1 : ((code == 7) ? -1 : 0);
        if (mMirror != 0) sR = -sR;
        if (mZoom != 0) begin
          mOx = clampInt(mOx + sR * rightX[mRot] + sD * downX[mRot], 0, IMG_W - WIN);
          mOy = clampInt(mOy + sR * rightY[mRot] + sD * downY[mRot], 0, IMG_H - WIN);
        end
      end
    endcase
  endfunction

  function automatic int expPix(input int p);
    int r, c, wr, wc, sr, sc;
    r = p / WIN;
    c = p % WIN;
    if (mMirror != 0) c = WIN - 1 - c;
    case (mRot)
      0: begin wr = r;           wc = c;           end
      1: begin wr = WIN - 1 - c; wc = r;           end
      2: begin wr = WIN - 1 - r; wc = WIN - 1 - c; end
      default: begin wr = c;     wc = WIN - 1 - r; end
    endcase
    if (mZoom != 0) begin
      sr = mOy + wr; sc = mOx + wc;
    end else begin
      sr = FOY + wr * FSY; sc = FOX + wc * FSX;
    end
    return frame[sr * IMG_W + sc];
  endfunction

  // Entered and left #1 after a rising edge; runs one command through to its busy drop.
  task automatic applyStimulus(input int code, input bit holdBusy);
    bit known;
    bit hold;
    known = isKnown(code);
    hold  = holdBusy && known;
    cmd = 4'(code);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    if (hold) cmd = 4'd3;
    else cmd_valid = 1'b0;
    if (!known) begin
      checkOutput($sformatf("busy_ignored_cmd%0d", code), int'(busy), 0);
      @(posedge clk); #1;
      checkOutput($sformatf("busy_still_idle_cmd%0d", code), int'(busy), 0);
      checkOutput($sformatf("valid_ignored_cmd%0d", code), int'(output_valid), 0);
    end else begin
      checkOutput($sformatf("busy_accept_cmd%0d", code), int'(busy), 1);
      modelAccept(code);
      if (code == 0) begin
        for (int i = 0; i < N; i++) begin
          datain = DW'(nextFrame[i]);
          @(posedge clk); #1;
        end
        checkOutput("valid_low_during_load", int'(output_valid), 0);
      end
      for (int p = 0; p < NPIX; p++) begin
        @(posedge clk); #1;
        checkOutput($sformatf("valid_p%0d_cmd%0d", p, code), int'(output_valid), 1);
        checkOutput($sformatf("pix_p%0d_cmd%0d", p, code), int'(dataout), expPix(p));
        if (p == 0) firstPix = int'(dataout);
      end
      lastPix = int'(dataout);
      @(posedge clk); #1;
      if (hold) cmd_valid = 1'b0;
      checkOutput($sformatf("busy_end_cmd%0d", code), int'(busy), 0);
      checkOutput($sformatf("valid_end_cmd%0d", code), int'(output_valid), 0);
      checkOutput($sformatf("dataout_hold_cmd%0d", code), int'(dataout), expPix(NPIX - 1));
      if (hold) begin
        @(posedge clk); #1;
        checkOutput("held_cmd_not_accepted", int'(busy), 0);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int code;
    int pick;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd       = 4'd0;
    datain    = '0;
    modelReset();
    for (int i = 0; i < N; i++) frame[i] = 0;

    #12;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_valid", int'(output_valid), 0);
    checkOutput("reset_dataout", int'(dataout), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < N; i++) nextFrame[i] = i;
    applyStimulus(0, 1'b0);
    checkOutput("spec_fit_first", firstPix, 13);
    checkOutput("spec_fit_last", lastPix, 94);

    applyStimulus(2, 1'b0);
    applyStimulus(2, 1'b0);
    checkOutput("spec_rot2_first", firstPix, 94);
    checkOutput("spec_rot2_last", lastPix, 13);
    applyStimulus(2, 1'b0);
    checkOutput("spec_rot3_first", firstPix, 22);
    applyStimulus(2, 1'b0);

    applyStimulus(3, 1'b0);
    checkOutput("spec_zoom_first", firstPix, 40);
    checkOutput("spec_zoom_last", lastPix, 79);
    repeat (10) applyStimulus(5, 1'b0);
    checkOutput("spec_shiftr_clamp", firstPix, 44);
    repeat (10) applyStimulus(8, 1'b0);
    checkOutput("spec_shiftd_clamp", firstPix, 68);

    applyStimulus(3, 1'b0);
    repeat (5) applyStimulus(6, 1'b0);
    repeat (4) applyStimulus(7, 1'b0);
    applyStimulus(2, 1'b0);
    applyStimulus(5, 1'b0);
    checkOutput("spec_rot1_shiftr_first", firstPix, 36);
    applyStimulus(8, 1'b0);
    checkOutput("spec_rot1_shiftd_first", firstPix, 37);

    applyStimulus(1, 1'b1);
    checkOutput("hold_rot0_first", firstPix, 1);
    applyStimulus(12, 1'b0);

    applyStimulus(4, 1'b0);
    applyStimulus(9, 1'b0);
    if (MIRROR_ON) checkOutput("spec_mirror_first", firstPix, 22);

    cmd = 4'd2;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("valid_before_abort", int'(output_valid), 1);
    reset_n = 1'b0;
    #1;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_valid", int'(output_valid), 0);
    checkOutput("abort_dataout", int'(dataout), 0);
    modelReset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1, 1'b0);

    for (int t = 0; t < 60; t++) begin
      pick = int'($urandom_range(0, 99));
      if (pick < 6) begin
        code = 0;
        for (int i = 0; i < N; i++) nextFrame[i] = int'($urandom_range(0, 255));
      end else if (pick < 12) begin
        code = int'($urandom_range(10, 15));
      end else begin
        code = int'($urandom_range(1, 9));
      end
      applyStimulus(code, ($urandom_range(0, 9) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
